// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and wrap-mode encodings.
// Used by gray_counter_n and by the FIFO pointer logic.
// The conversion functions work on a 32-bit container. A narrower value must
// be zero-extended before the call and truncated afterwards. Zero upper bits
// leave the result of either conversion unchanged.
package gray_pkg;

  // End-of-range behaviour selector for the WRAP parameter.
  localparam int WRAP_SAT = 0;  // hold at the end of the range
  localparam int WRAP_MOD = 1;  // modulo 2^WIDTH wrap-around

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB downwards.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gv);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = gv[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gv[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter.
// Ports:
//   i_gray : WIDTH-bit Gray-coded input
//   o_bin  : WIDTH-bit binary equivalent
// bin[MSB] = g[MSB], and bin[i] = bin[i+1] ^ g[i] for the lower bits. The
// XOR chain ripples from the MSB, so its depth grows linearly with WIDTH.
module gray2bin_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin[WIDTH-1] = i_gray[WIDTH-1];

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_prefix_xor
    assign o_bin[gi] = o_bin[gi+1] ^ i_gray[gi];
  end

endmodule

// File: rtl/gray_counter_n.sv
// Registered up/down counter with a binary value and its Gray code.
// Ports:
//   clk          : clock. All state changes on the rising edge.
//   rst          : synchronous active-high reset
//   en           : count enable for this cycle
//   up           : direction (1 counts up, 0 counts down)
//   load         : load load_val this cycle (takes priority over en)
//   load_is_gray : 1 means load_val is Gray-coded, 0 means it is binary
//   load_val     : value to load
//   bin          : registered binary count
//   g            : registered Gray code of bin
//   wrap         : registered one-cycle pulse on a wrap or a blocked end step
// The same edge loads g and bin from one next-state value. g is never decoded
// after the flop, so it stays glitch-free for clock-domain crossing.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int WRAP  = WRAP_MOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] g,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_g;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_g_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_min;

  gray2bin_n #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .i_gray (load_val),
    .o_bin  (w_load_bin)
  );

  assign w_at_max = (r_bin == MAX_VAL);
  assign w_at_min = (r_bin == MIN_VAL);

  // Next-state mux. Load beats enable, and reset is applied in the flop
  // process. At an end of the range the step either wraps to the opposite
  // end or holds, depending on the mode. The wrap pulse is raised in both
  // cases.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = load_is_gray ? w_load_bin : load_val;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
          w_wrap_next = 1'b1;
          w_bin_next  = (WRAP == WRAP_MOD) ? MIN_VAL : MAX_VAL;
        end else begin
          w_bin_next = r_bin + 1'b1;
        end
      end else begin
        if (w_at_min) begin
          w_wrap_next = 1'b1;
          w_bin_next  = (WRAP == WRAP_MOD) ? MAX_VAL : MIN_VAL;
        end else begin
          w_bin_next = r_bin - 1'b1;
        end
      end
    end
  end

  assign w_g_next = WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_next)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_g    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_g    <= w_g_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin  = r_bin;
  assign g    = r_g;
  assign wrap = r_wrap;

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised, registered up/down Gray-code counter, the sequential successor to the fixed 3-bit binary-to-Gray converter. It keeps a binary count internally and presents both the binary value and its Gray encoding as registered outputs. A load port accepts the start value in either binary or Gray form. It serves as a pointer and position source for clock-domain-crossing FIFOs and encoder interfaces in the same design.

## Interface
- `WIDTH`, default 3: counter width in bits. Must be 2 or more.
- `WRAP`, default 1: end-of-range behaviour. 1 means modulo-2^WIDTH wrap; 0 means saturate at the end of the range.
- `clk` input, 1: the single clock. All state updates on its rising edge.
- `rst` input, 1: reset. Synchronous and active-high.
- `en` input, 1: count enable for the current cycle.
- `up` input, 1: direction. 1 increments; 0 decrements.
- `load` input, 1: load `load_val` this cycle.
- `load_is_gray` input, 1: 1 means `load_val` is Gray-coded; 0 means it is binary.
- `load_val` input, WIDTH: value to load.
- `bin` output, WIDTH: registered binary count.
- `g` output, WIDTH: registered Gray code of `bin`.
- `wrap` output, 1: registered one-cycle pulse on a wrap, or on a blocked step at the end of the range.

## Operation
- Priority per cycle: `rst`, then `load`, then `en`, then hold.
- Reset: `bin`=0, `g`=0, `wrap`=0.
- Load with `load_is_gray`=0: `bin` takes `load_val` directly.
- Load with `load_is_gray`=1: `bin` takes the Gray-to-binary conversion of `load_val`.
  - Conversion rule: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i].
- `wrap` is always 0 in a load cycle. `en` and `up` are ignored in a load cycle.
- Count with `en`=1 and `up`=1:
  - `WRAP`=1: `bin` becomes `bin`+1 modulo 2^WIDTH. Stepping max to 0 sets `wrap`=1.
  - `WRAP`=0: `bin` stops at max. Attempting to step past max holds `bin` and sets `wrap`=1.
- Count with `en`=1 and `up`=0: mirror of the above. The boundary is 0 to max with `WRAP`=1; the saturation point is 0 with `WRAP`=0.
- Idle with `en`=0 and `load`=0: all state holds and `wrap`=0.
- `g` equals `bin` ^ (`bin`>>1) at all times.
  - Both outputs are loaded from the same next-state value in the same edge, so they never disagree.
  - `g` is registered, not decoded combinationally after the flop. This keeps it glitch-free for CDC.
- No arithmetic overflow beyond WIDTH bits. Carry and borrow are discarded; only the `wrap` flag reports them.

## Timing
- Latency is one cycle for everything:
  - Inputs are sampled on edge N.
  - `bin`, `g` and `wrap` reflect them after edge N.
- Reset behaviour:
  - Reset takes effect on the first edge at which `rst` is high.
  - Reset overrides a simultaneous `load` or `en`.
  - Reset mid-count discards the count immediately; there is no partial step.
- `wrap` is high for exactly one cycle per boundary event.
  - Under continuous saturation attempts (`WRAP`=0, `en` held), it stays high every cycle.
- Direction may change on any cycle with no penalty; each step uses the `up` sampled in that same cycle.
- Consecutive `g` values differ in exactly one bit whenever `en` steps the count, including across a `WRAP`=1 boundary.

## Structure
- Shared package `gray_pkg` holds:
  - functions `bin2gray(WIDTH)` and `gray2bin(WIDTH)`;
  - localparams for the `WRAP` mode encodings.
  - The package is reused by the FIFO pointer logic.
- One sub-module, `gray2bin_n`:
  - parametrised and combinational;
  - performs the prefix-XOR load conversion;
  - instantiated once on `load_val`.
- The top level holds the binary register, the next-state mux, the saturation/wrap compare and the output flops.

## Test plan
- Reset and up-count, `WIDTH`=3, `WRAP`=1: `rst` for 1 cycle, then `en`=1, `up`=1 for 9 cycles.
  - Required `g`: 000, 001, 011, 010, 110, 111, 101, 100, 000.
  - Required `wrap`: 1 only in the cycle `bin` returns to 0.
- Gray load, `WIDTH`=3: `load`=1, `load_is_gray`=1, `load_val`=110.
  - Required next cycle: `bin`=4, `g`=110, `wrap`=0.
  - Then `en`=1, `up`=0 for one cycle: required `bin`=3, `g`=010.
- Down wrap, `WIDTH`=3, `WRAP`=1: from `bin`=0, step down once.
  - Required: `bin`=7, `g`=100, `wrap`=1 for one cycle.
- Saturation, `WIDTH`=3, `WRAP`=0: load binary 6, then `en`=1, `up`=1 for 3 cycles.
  - Required `bin`: 7, 7, 7.
  - Required `wrap`: 0, 1, 1.
- Priority: assert `rst`, `load` (`load_val`=5) and `en` together, then release `rst` only.
  - Required after the first edge: `bin`=0.
  - Required after the next edge: `bin`=5.
- Exhaustive single-bit-change check, `WIDTH`=8, `WRAP`=1: run 512 random-direction enabled steps.
  - Required every step: popcount(`g` ^ previous `g`)=1.
  - Required every cycle: `g`=`bin`^(`bin`>>1).
